csa_pipe_addsub: RTL and testbench
==================================

Name: csa_pipe_addsub

Overview:
- Parametrised, pipelined carry-select adder/subtractor. It generalises the team's 4-bit combinational carry-select adder.
- Operand width is split into BLOCK-bit carry-select segments, with one pipeline register stage per segment.
- Adds subtract mode, signed-overflow flag and a valid/ready handshake with backpressure.
- Sits in the datapath library as the standard streaming add/sub unit.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of BLOCK.
- BLOCK, 4, carry-select segment width in bits; must be >= 2.
- NBLK is derived as WIDTH/BLOCK: the number of segments and the pipeline depth.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; clears all valid and output state.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- A  input  WIDTH  operand A (unsigned or two's complement).
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in; used in add mode only.
- Sub  input  1  0 = A+B+Cin; 1 = A-B (A + ~B + 1), Cin ignored.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- Sum  output  WIDTH  result.
- Carry  output  1  carry-out of MSB; in subtract mode this is the not-borrow flag (1 when A >= B unsigned).
- Overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset, asynchronous: all stage valid bits = 0, out_valid = 0, Sum = 0, Carry = 0, Overflow = 0, all internal carry and partial-sum registers = 0.
- Reset asserted mid-operation discards every in-flight beat. No result emerges for beats accepted before reset.
- Operand conditioning at capture: Bx = Sub ? ~B : B; c0 = Sub ? 1 : Cin.
- Stage 0 (segment 0, bits BLOCK-1:0):
  - ripple-adds A[seg0] + Bx[seg0] + c0;
  - registers the segment sum, the segment carry-out, and the remaining A/Bx upper bits plus Sub.
- Stage k, for 1 <= k < NBLK, segment k:
  - computes two candidate sums/carries combinationally: one with carry-in 0, one with carry-in 1;
  - selects the pair using the carry registered by stage k-1;
  - registers the accumulated lower sum bits, the selected carry, and the still-unused operand bits.
- Overflow is computed in the last stage from the MSB segment: the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
- The last stage's registers drive Sum/Carry/Overflow/out_valid directly; there is no combinational path from inputs to outputs.
- Latency: NBLK cycles from the in_valid&&in_ready edge to out_valid, assuming no stalls (4 cycles at the defaults).
- Throughput: one beat per cycle when out_ready = 1.
- Pipeline control uses a global stall: advance = out_ready || !out_valid.
  - in_ready = advance; this is combinational from out_ready and out_valid.
  - When advance = 0, every stage, including the outputs, holds its value.
  - Sum/Carry/Overflow stay stable while out_valid && !out_ready.
- Bubbles:
  - A cycle with in_valid = 0 and advance = 1 inserts an invalid stage-0 entry.
  - Bubbles propagate and collapse when they reach the output while out_valid = 0.
  - Data registers may update under a bubble, but out_valid = 0 for it.
- Simultaneous accept and emit in the same cycle is legal and loses no data.
- When out_valid = 0, output data holds its last value (after reset, that value is 0).
- Results are ordered strictly first-in, first-out.
- Arithmetic wraps modulo 2^WIDTH. Carry and Overflow are both reported; the bench interprets them according to signedness.
- Elaboration error if WIDTH % BLOCK != 0 or BLOCK < 2.

Test Plan (defaults WIDTH=16, BLOCK=4, latency 4):
- Reset and basic add, Sub=0, Cin=0, outputs checked 4 cycles after acceptance:
  - rst pulse → all outputs 0 and in_ready = 1;
  - A=16'h00FF, B=16'h0001 → Sum=16'h0100, Carry=0, Overflow=0.
- Full carry chain across all segments plus Cin:
  - A=16'hFFFF, B=16'h0000, Cin=1 → Sum=16'h0000, Carry=1, Overflow=0;
  - A=16'h7FFF, B=16'h0001, Cin=0 → Sum=16'h8000, Carry=0, Overflow=1.
- Subtract mode:
  - A=16'h0005, B=16'h0007, Sub=1, Cin=1 (ignored) → Sum=16'hFFFE, Carry=0, Overflow=0;
  - A=16'h8000, B=16'h0001, Sub=1 → Sum=16'h7FFF, Carry=1, Overflow=1.
- Streaming with backpressure:
  - 8 back-to-back beats A=i, B=16'h1000*i (i=1..8), with out_ready held low for 3 cycles after the first result;
  - required: in_ready low during the stall, first result held stable, all 8 results emerge in order with no loss or duplication, and throughput returns to 1 beat/cycle.
- Reset mid-operation:
  - accept 3 beats, assert rst 2 cycles later;
  - required: out_valid = 0 immediately and no stale results after release;
  - a new beat A=16'h1234, B=16'h4321 yields Sum=16'h5555 exactly 4 cycles after acceptance.
- Parameter sweep:
  - WIDTH=8, BLOCK=2 (latency 4) and WIDTH=32, BLOCK=8;
  - 1000 random A/B/Cin/Sub beats compared against a behavioural model ({Carry,Sum} = A + Bx + c0, Overflow by sign rule), with random out_ready.

Source files
------------

// File: rtl/csa_pipe_addsub.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit segment is resolved per stage,
// behind a valid/ready streaming interface with a single global stall.
module csa_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow
);
    localparam int NBLK = WIDTH / BLOCK;

    if ((WIDTH % BLOCK) != 0 || BLOCK < 2) begin : g_param_check
        $error("csa_pipe_addsub: WIDTH must be a multiple of BLOCK and BLOCK must be >= 2");
    end

    // Global stall: the whole pipe moves together or not at all.
    logic advance;
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        localparam int LO  = k * BLOCK;
        localparam int HI  = LO + BLOCK;
        localparam int REM = WIDTH - LO;

        logic           v_in;
        logic [REM-1:0] op_a;
        logic [REM-1:0] op_b;
        logic [BLOCK:0] seg;
        logic [HI-1:0]  sum_d;
        logic [HI-1:0]  sum_q;
        logic           carry_q;
        logic           valid_q;

        if (k == 0) begin : g_first
            logic c_in;
            assign v_in  = in_valid;
            assign op_a  = A;
            assign op_b  = Sub ? ~B : B;
            assign c_in  = Sub | Cin;
            assign seg   = {1'b0, op_a[BLOCK-1:0]} + {1'b0, op_b[BLOCK-1:0]}
                         + {{BLOCK{1'b0}}, c_in};
            assign sum_d = seg[BLOCK-1:0];
        end else begin : g_select
            logic [BLOCK:0] cand0;
            logic [BLOCK:0] cand1;
            assign v_in  = g_stage[k-1].valid_q;
            assign op_a  = g_stage[k-1].g_ops.a_q;
            assign op_b  = g_stage[k-1].g_ops.bx_q;
            // Both carry-in outcomes are ready before the lower segment's carry selects one.
            assign cand0 = {1'b0, op_a[BLOCK-1:0]} + {1'b0, op_b[BLOCK-1:0]};
            assign cand1 = {1'b0, op_a[BLOCK-1:0]} + {1'b0, op_b[BLOCK-1:0]} + (BLOCK+1)'(1);
            assign seg   = g_stage[k-1].carry_q ? cand1 : cand0;
            assign sum_d = {seg[BLOCK-1:0], g_stage[k-1].sum_q};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                // NOTE: data registers are reset as well as valids, so Sum/Carry read 0 after reset.
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                // NOTE: non-blocking assignments keep every stage sampling pre-edge values.
                valid_q <= v_in;
                if (v_in) begin
                    carry_q <= seg[BLOCK];
                    sum_q   <= sum_d;
                end
            end
        end

        if (HI < WIDTH) begin : g_ops
            logic [WIDTH-HI-1:0] a_q;
            logic [WIDTH-HI-1:0] bx_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q  <= '0;
                    bx_q <= '0;
                end else if (advance && v_in) begin
                    a_q  <= op_a[REM-1:BLOCK];
                    bx_q <= op_b[REM-1:BLOCK];
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
            assign ovf_d = seg[BLOCK] ^ (seg[BLOCK-1] ^ op_a[BLOCK-1] ^ op_b[BLOCK-1]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance && v_in) begin
                    ovf_q <= ovf_d;
                end
            end

            assign Sum       = sum_q;
            assign Carry     = carry_q;
            assign Overflow  = ovf_q;
            assign out_valid = valid_q;
        end
    end

endmodule

// File: tb/tb_csa_pipe_addsub.sv
// Scoreboard bench for csa_pipe_addsub at 16/4, 8/2 and 32/8, with a plain-arithmetic
// reference model and a per-instance monitor that pops expected results on each output beat.
module tb_csa_pipe_addsub;
    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic busy = 1'b0;

    logic        v16, r16, ov16, or16, cin16, sub16, c16, o16;
    logic [15:0] a16, b16, s16;
    logic        v8, r8, ov8, or8, cin8, sub8, c8, o8;
    logic [7:0]  a8, b8, s8;
    logic        v32, r32, ov32, or32, cin32, sub32, c32, o32;
    logic [31:0] a32, b32, s32;

    res_t q16[$], q8[$], q32[$];
    res_t e16, e8, e32;

    csa_pipe_addsub #(.WIDTH(16), .BLOCK(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .A(a16), .B(b16),
        .Cin(cin16), .Sub(sub16), .out_valid(ov16), .out_ready(or16), .Sum(s16),
        .Carry(c16), .Overflow(o16));

    csa_pipe_addsub #(.WIDTH(8), .BLOCK(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .A(a8), .B(b8),
        .Cin(cin8), .Sub(sub8), .out_valid(ov8), .out_ready(or8), .Sum(s8),
        .Carry(c8), .Overflow(o8));

    csa_pipe_addsub #(.WIDTH(32), .BLOCK(8)) u32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .A(a32), .B(b32),
        .Cin(cin32), .Sub(sub32), .out_valid(ov32), .out_ready(or32), .Sum(s32),
        .Carry(c32), .Overflow(o32));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {Carry,Sum} = A + Bx + c0 modulo 2^w; overflow when equal-sign operands give a different-sign sum.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb);
        longint unsigned mask, aa, bx, tot;
        logic sa, sx, ss;
        res_t r;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bx   = {32'd0, b} & mask;
        if (sb) bx = ~bx & mask;
        tot  = aa + bx + ((sb || ci) ? 64'd1 : 64'd0);
        sa   = aa[w-1];
        sx   = bx[w-1];
        ss   = tot[w-1];
        r.sum   = 32'(tot & mask);
        r.carry = tot[w];
        r.ovf   = (sa == sx) && (ss != sa);
        return r;
    endfunction

    // Monitors: a result is consumed on every negedge where out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && ov16 && or16) begin
            if (q16.size() == 0) check("u16_spurious_result", 32'(ov16), 32'd0);
            else begin
                e16 = q16.pop_front();
                check("u16_sum", 32'(s16), e16.sum);
                check("u16_carry", 32'(c16), 32'(e16.carry));
                check("u16_overflow", 32'(o16), 32'(e16.ovf));
            end
        end
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) check("u8_spurious_result", 32'(ov8), 32'd0);
            else begin
                e8 = q8.pop_front();
                check("u8_sum", 32'(s8), e8.sum);
                check("u8_carry", 32'(c8), 32'(e8.carry));
                check("u8_overflow", 32'(o8), 32'(e8.ovf));
            end
        end
        if (!rst && ov32 && or32) begin
            if (q32.size() == 0) check("u32_spurious_result", 32'(ov32), 32'd0);
            else begin
                e32 = q32.pop_front();
                check("u32_sum", s32, e32.sum);
                check("u32_carry", 32'(c32), 32'(e32.carry));
                check("u32_overflow", 32'(o32), 32'(e32.ovf));
            end
        end
    end

    // Reset discards every in-flight beat, so its expectations go too.
    always @(posedge rst) begin
        q16.delete();
        q8.delete();
        q32.delete();
    end

    // Entered #1 after a posedge; returns #1 after the edge that accepted the beat.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic sb, input res_t e);
        a16 = a; b16 = b; cin16 = ci; sub16 = sb; v16 = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (r16) break;
            if (t == 200) begin
                check("u16_in_ready_timeout", 32'(r16), 32'd1);
                v16 = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        q16.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic rand16(input int n);
        logic [15:0] a, b;
        logic ci, sb;
        for (int i = 0; i < n; i++) begin
            a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sb = 1'($urandom);
            if ($urandom_range(0, 4) == 0) begin v16 = 1'b0; @(posedge clk); #1; end
            send16(a, b, ci, sb, model(16, 32'(a), 32'(b), ci, sb));
        end
        v16 = 1'b0;
    endtask

    task automatic rand8(input int n);
        logic [7:0] a, b;
        logic ci, sb;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sb = 1'($urandom);
            if ($urandom_range(0, 4) == 0) begin v8 = 1'b0; @(posedge clk); #1; end
            a8 = a; b8 = b; cin8 = ci; sub8 = sb; v8 = 1'b1;
            for (int t = 0; ; t++) begin
                @(negedge clk);
                if (r8) break;
                if (t == 200) begin
                    check("u8_in_ready_timeout", 32'(r8), 32'd1);
                    v8 = 1'b0;
                    return;
                end
                @(posedge clk); #1;
            end
            q8.push_back(model(8, 32'(a), 32'(b), ci, sb));
            @(posedge clk); #1;
        end
        v8 = 1'b0;
    endtask

    task automatic rand32(input int n);
        logic [31:0] a, b;
        logic ci, sb;
        for (int i = 0; i < n; i++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom); sb = 1'($urandom);
            if ($urandom_range(0, 4) == 0) begin v32 = 1'b0; @(posedge clk); #1; end
            a32 = a; b32 = b; cin32 = ci; sub32 = sb; v32 = 1'b1;
            for (int t = 0; ; t++) begin
                @(negedge clk);
                if (r32) break;
                if (t == 200) begin
                    check("u32_in_ready_timeout", 32'(r32), 32'd1);
                    v32 = 1'b0;
                    return;
                end
                @(posedge clk); #1;
            end
            q32.push_back(model(32, a, b, ci, sb));
            @(posedge clk); #1;
        end
        v32 = 1'b0;
    endtask

    // Called #1 after the accepting edge; out_valid must rise only after the 4th edge.
    task automatic expect_latency(input string name);
        for (int e = 1; e <= 4; e++) begin
            check(name, 32'(ov16), (e == 4) ? 32'd1 : 32'd0);
            if (e < 4) begin @(posedge clk); #1; end
        end
    endtask

    vec_t vecs[5] = '{
        '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        v16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; or16 = 1;
        v8  = 0; a8  = 0; b8  = 0; cin8  = 0; sub8  = 0; or8  = 1;
        v32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; or32 = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(ov16), 32'd0);
        check("reset_sum", 32'(s16), 32'd0);
        check("reset_carry", 32'(c16), 32'd0);
        check("reset_overflow", 32'(o16), 32'd0);
        check("reset_in_ready", 32'(r16), 32'd1);
        check("reset_u8_out_valid", 32'(ov8), 32'd0);
        check("reset_u32_sum", s32, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, each timed from acceptance to result.
        foreach (vecs[i]) begin
            send16(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb,
                   res_t'{32'(vecs[i].s), vecs[i].c, vecs[i].o});
            v16 = 1'b0;
            expect_latency($sformatf("latency_vec%0d", i));
            repeat (3) @(posedge clk); #1;
        end

        // Back-to-back stream with a 3-cycle stall on the first result.
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send16(16'(i), 16'(32'h1000 * i), 1'b0, 1'b0,
                           res_t'{32'h1001 * 32'(i), 1'b0, 1'b0});
                v16 = 1'b0;
            end
            begin
                for (int t = 0; t < 50 && !ov16; t++) begin @(posedge clk); #1; end
                check("stream_first_result_seen", 32'(ov16), 32'd1);
                or16 = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check("stall_in_ready_low", 32'(r16), 32'd0);
                    check("stall_out_valid_held", 32'(ov16), 32'd1);
                    check("stall_sum_held", 32'(s16), 32'h1001);
                    @(posedge clk); #1;
                end
                or16 = 1'b1;
                for (int s = 0; s < 8; s++) begin
                    @(negedge clk);
                    check("stream_one_per_cycle", 32'(ov16), 32'd1);
                    @(posedge clk); #1;
                end
            end
        join
        repeat (4) @(posedge clk); #1;
        check("stream_all_drained", 32'(q16.size()), 32'd0);

        // Reset while three beats are in flight.
        for (int i = 0; i < 3; i++)
            send16(16'(i * 3 + 1), 16'h0101, 1'b0, 1'b0, model(16, 32'(i * 3 + 1), 32'h0101, 1'b0, 1'b0));
        v16 = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midreset_out_valid", 32'(ov16), 32'd0);
        check("midreset_sum", 32'(s16), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midreset_no_stale", 32'(ov16), 32'd0);
        end
        @(posedge clk); #1;
        send16(16'h1234, 16'h4321, 1'b0, 1'b0, res_t'{32'h5555, 1'b0, 1'b0});
        v16 = 1'b0;
        expect_latency("latency_after_reset");
        @(posedge clk); #1;

        // Random beats with random backpressure, default parameters.
        busy = 1'b1;
        fork
            begin rand16(300); busy = 1'b0; end
            begin
                while (busy) begin @(posedge clk); #1; or16 = ($urandom_range(0, 3) != 0); end
            end
        join
        or16 = 1'b1;

        // Parameter sweep instances.
        busy = 1'b1;
        fork
            begin
                fork
                    rand8(1000);
                    rand32(1000);
                join
                busy = 1'b0;
            end
            begin
                while (busy) begin
                    @(posedge clk); #1;
                    or8  = ($urandom_range(0, 3) != 0);
                    or32 = ($urandom_range(0, 3) != 0);
                end
            end
        join
        or8 = 1'b1;
        or32 = 1'b1;

        for (int t = 0; t < 200 && (q16.size() + q8.size() + q32.size()) != 0; t++)
            @(posedge clk);
        #1;
        check("final_drain_u16", 32'(q16.size()), 32'd0);
        check("final_drain_u8", 32'(q8.size()), 32'd0);
        check("final_drain_u32", 32'(q32.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
